// File: rtl/wb_fpga_cfg_loader_if.sv
// Wishbone slave bus bundle for the configuration loader.
// Signal names follow the Caravel wishbone slave port.
interface wb_fpga_cfg_loader_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_fpga_cfg_loader.sv
// Wishbone-fed bitstream loader: a word FIFO drains into NUM_CHAINS parallel
// configuration scan chains, followed by a one-cycle latch pulse.
module wb_fpga_cfg_loader #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          NUM_CHAINS = 4,
   parameter int          FIFO_DEPTH = 8,
   parameter int          CNT_W      = 20
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   wb_fpga_cfg_loader_if.slave    wb,
   output logic [NUM_CHAINS-1:0]  cfg_data_o,
   output logic                   cfg_en_o,
   output logic                   cfg_latch_o,
   output logic                   cfg_busy_o
);
   localparam int SLICES = 32 / NUM_CHAINS;
   localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam logic [SL_W-1:0] LAST_SLICE = SL_W'(SLICES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_ack, r_wr_en, r_busy, r_done, r_under, r_latch;
   logic [1:0]        r_wr_reg;
   logic [31:0]       r_wr_dat, r_rdat, w_rdat, r_sreg;
   logic [CNT_W-1:0]  r_len, r_remaining;
   logic [SL_W-1:0]   r_slice;
   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [PTR_W:0]    r_count;
   logic              w_req, w_hit, w_stall, w_grant, w_full, w_empty;
   logic              w_abort, w_start, w_push, w_pop, w_finish, w_set_under;
   logic              w_unused_bits;

   assign w_unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

   // Bus side: requests are granted one cycle early and executed in the ack cycle.
   assign w_req   = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack;
   assign w_hit   = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_stall = w_hit & wb.wbs_we_i & (wb.wbs_adr_i[3:2] == 2'd2) & w_full;
   assign w_grant = w_req & ~w_stall;

   assign w_abort = r_wr_en & (r_wr_reg == 2'd0) & r_wr_dat[1];
   assign w_start = r_wr_en & (r_wr_reg == 2'd0) & r_wr_dat[0] & ~r_wr_dat[1];
   assign w_push  = r_wr_en & (r_wr_reg == 2'd2);

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_rdat = '0;
      case (wb.wbs_adr_i[3:2])
         2'd0:    w_rdat[1:0] = {r_done, r_busy};
         2'd1:    w_rdat[CNT_W-1:0] = r_len;
         2'd3: begin
            w_rdat[4:0]  = {r_under, w_empty, w_full, r_done, r_busy};
            w_rdat[15:8] = 8'(r_count);
         end
         default: w_rdat = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack    <= 1'b0;
         r_rdat   <= '0;
         r_wr_en  <= 1'b0;
         r_wr_reg <= '0;
         r_wr_dat <= '0;
         r_len    <= '0;
      end else begin
         r_ack    <= w_grant;
         r_rdat   <= (w_grant & ~wb.wbs_we_i & w_hit) ? w_rdat : '0;
         r_wr_en  <= w_grant & wb.wbs_we_i & w_hit;
         r_wr_reg <= wb.wbs_adr_i[3:2];
         r_wr_dat <= wb.wbs_dat_i;
         if (r_wr_en && r_wr_reg == 2'd1) r_len <= r_wr_dat[CNT_W-1:0];
      end
   end

   assign wb.wbs_ack_o = r_ack;
   assign wb.wbs_dat_o = r_rdat;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || w_abort) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
   end

   // NOTE: the FIFO storage has no reset; the pointers and count alone define its contents.
   always_ff @(posedge wb_clk_i) begin
      if (w_push) r_mem[r_wptr] <= r_wr_dat;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_finish    = 1'b0;
      w_set_under = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = (r_len == '0) ? S_IDLE : S_LOAD;
               w_finish    = (r_len == '0);
            end
         end
         S_LOAD: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SHIFT;
            end else begin
               w_set_under = 1'b1;
            end
         end
         S_SHIFT: begin
            if (r_remaining == CNT_W'(1)) begin
               w_state_nxt = S_IDLE;
               w_finish    = 1'b1;
            end else if (r_slice == LAST_SLICE) begin
               if (!w_empty) w_pop = 1'b1;
               else          w_state_nxt = S_LOAD;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) begin
         w_state_nxt = S_IDLE;
         w_pop       = 1'b0;
         w_finish    = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_latch     <= 1'b0;
         r_done      <= 1'b0;
         r_under     <= 1'b0;
         r_remaining <= '0;
         r_slice     <= '0;
         r_sreg      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_latch <= w_finish;
         if (r_state == S_IDLE && w_start) begin
            r_done      <= 1'b0;
            r_under     <= 1'b0;
            r_remaining <= r_len;
         end
         if (w_finish)    r_done  <= 1'b1;
         if (w_set_under) r_under <= 1'b1;
         if (r_state == S_SHIFT) begin
            r_remaining <= r_remaining - CNT_W'(1);
            r_slice     <= r_slice + SL_W'(1);
            r_sreg      <= r_sreg >> NUM_CHAINS;
         end
         // A pop in the last-slice cycle reloads the word with no bubble.
         if (w_pop) begin
            r_sreg  <= r_mem[r_rptr];
            r_slice <= '0;
         end
      end
   end

   assign cfg_en_o    = (r_state == S_SHIFT);
   assign cfg_data_o  = cfg_en_o ? r_sreg[NUM_CHAINS-1:0] : '0;
   assign cfg_latch_o = r_latch;
   assign cfg_busy_o  = r_busy;
endmodule
